// File: rtl/ual_seq.sv
// Sequential arithmetic unit: single-cycle add/sub/compare and a WIDTH-cycle
// shift-add multiplier, with registered result and flags.
module ual_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               zero,
  output logic               eq,
  output logic               lt
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state, state_d;
  logic [RW-1:0]    acc, acc_d, ma, ma_d, acc_sum;
  logic [WIDTH-1:0] mb, mb_d, a_l, a_l_d, b_l, b_l_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [RW-1:0]    result_d;
  logic             zero_d, eq_d, lt_d, busy_d, done_d;
  logic [WIDTH:0]   sum_w, diff_w;

  // Next-state and datapath; result/flags only move on a completion.
  always_comb begin
    state_d  = state;
    acc_d    = acc;
    ma_d     = ma;
    mb_d     = mb;
    a_l_d    = a_l;
    b_l_d    = b_l;
    cnt_d    = cnt;
    result_d = result;
    zero_d   = zero;
    eq_d     = eq;
    lt_d     = lt;
    sum_w    = {1'b0, a} + {1'b0, b};
    diff_w   = {1'b0, a} - {1'b0, b};
    acc_sum  = acc + (mb[0] ? ma : RW'(0));

    case (state)
      IDLE, DONE: begin
        if (state == DONE) state_d = IDLE;
        if (start) begin
          a_l_d = a;
          b_l_d = b;
          if (op == OP_MUL) begin
            state_d = MUL;
            acc_d   = '0;
            cnt_d   = '0;
            ma_d    = RW'(a);
            mb_d    = b;
          end else begin
            state_d = DONE;
            case (op)
              OP_ADD:  result_d = RW'(sum_w);
              OP_SUB:  result_d = RW'(diff_w);
              default: result_d = '0;
            endcase
            zero_d = (result_d == '0);
            eq_d   = (a == b);
            lt_d   = (a < b);
          end
        end
      end
      MUL: begin
        // One multiplier bit per cycle, LSB first.
        acc_d = acc_sum;
        ma_d  = ma << 1;
        mb_d  = mb >> 1;
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          result_d = acc_sum;
          zero_d   = (acc_sum == '0);
          eq_d     = (a_l == b_l);
          lt_d     = (a_l < b_l);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == MUL);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      ma     <= '0;
      mb     <= '0;
      a_l    <= '0;
      b_l    <= '0;
      cnt    <= '0;
      result <= '0;
      zero   <= 1'b1;
      eq     <= 1'b0;
      lt     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      acc    <= acc_d;
      ma     <= ma_d;
      mb     <= mb_d;
      a_l    <= a_l_d;
      b_l    <= b_l_d;
      cnt    <= cnt_d;
      result <= result_d;
      zero   <= zero_d;
      eq     <= eq_d;
      lt     <= lt_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

endmodule

// File: doc/ual_seq.md
UAL_SEQ -- requirements
Module: ual_seq

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, operand width in bits (legal range 2..16).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port: start  input  1  request pulse, sampled on the rising edge.
REQ-005 SHALL have port: op  input  2  operation: 00 add, 01 sub, 10 mult, 11 compare.
REQ-006 SHALL have port: a  input  WIDTH  operand A, unsigned.
REQ-007 SHALL have port: b  input  WIDTH  operand B, unsigned.
REQ-008 SHALL have port: busy  output  1  operation in progress; start is ignored.
REQ-009 SHALL have port: done  output  1  one-cycle pulse, result and flags valid.
REQ-010 SHALL have port: result  output  2*WIDTH  registered result.
REQ-011 SHALL have port: zero  output  1  result == 0, registered with result.
REQ-012 SHALL have port: eq  output  1  a == b from the latched operands, registered with result.
REQ-013 SHALL have port: lt  output  1  a < b (unsigned) from the latched operands, registered with result.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DONE.
REQ-015 SHALL accept start only in IDLE or DONE: latch a, b and op on that edge; later input changes SHALL NOT affect the operation.
REQ-016 SHALL treat start as ignored while busy=1, with no effect on latched operands, state or outputs.
REQ-017 SHALL, for accepted add/sub/compare, compute on the accept edge and enter DONE; done=1 in the following cycle (latency 1).
REQ-018 SHALL form add result as a+b zero-extended: bit WIDTH = carry out, upper bits 0.
REQ-019 SHALL form sub result as low WIDTH bits = (a-b) mod 2^WIDTH, bit WIDTH = borrow (1 iff a<b), upper bits 0.
REQ-020 SHALL set compare result to 0, so zero=1, with eq/lt valid.
REQ-021 SHALL compute eq and lt for every op, not only compare.
REQ-022 SHALL, for accepted mult, enter MUL with accumulator=0 and iteration counter=0, and assert busy.
REQ-023 SHALL process one multiplier bit per MUL cycle, LSB first (shift-add), for exactly WIDTH cycles, then enter DONE.
REQ-024 SHALL give done for mult WIDTH+1 cycles after the accept edge, with the full 2*WIDTH-bit unsigned product and no truncation.
REQ-025 SHALL hold busy=1 in MUL and busy=0 in IDLE and DONE.
REQ-026 SHALL hold done=1 only in DONE, for exactly one cycle.
REQ-027 SHALL go DONE -> IDLE when start=0; start=1 in DONE is accepted as in IDLE (back-to-back issue).
REQ-028 SHALL hold result, zero, eq and lt stable from done until the next completion; they SHALL NOT change during MUL.
REQ-029 SHALL keep the counter width ceil(log2(WIDTH+1)) with no wrap for any legal WIDTH.

Reset
REQ-030 SHALL, while rst_n=0 at a rising edge, set state=IDLE, busy=0, done=0, result=0, zero=1, eq=0, lt=0, counter and accumulator=0.
REQ-031 SHALL let reset override start and abort an in-flight mult with no done pulse; start on the edge rst_n returns high SHALL be accepted normally.

Verification
REQ-032 SHALL cover add, WIDTH=4: a=12, b=15, op=00, start pulse -> next cycle done=1, result=27 (bit4 carry=1), lt=1, eq=0.
REQ-033 SHALL cover sub, WIDTH=4: a=14, b=11, op=01 -> result=3, borrow=0; then a=3, b=5 -> low nibble=14, bit4=1.
REQ-034 SHALL cover mult, WIDTH=4: a=8, b=9, op=10 -> busy for 4 cycles, done on 5th cycle, result=72; a=15, b=15 -> 225.
REQ-035 SHALL cover ignored start: during mult 8*9, start with op=00, a=1, b=1 mid-MUL -> still result=72 at cycle 5, no extra done.
REQ-036 SHALL cover reset abort: rst_n=0 at MUL cycle 2 -> no done, result=0, zero=1, busy=0; a new add is accepted after release.
REQ-037 SHALL cover WIDTH=8: a=255, b=255, op=10 -> done after 9 cycles, result=65025; compare a=b=7 -> eq=1, zero=1.
